// File: rtl/hangman_guess_sequencer_pkg.sv
// Hangman sequencer shared types and constants.
// States, alphabet bounds and letter codes.
package hangman_pkg;

  localparam int WORD_LEN_D  = 5;
  localparam int MAX_TRIES_D = 6;
  localparam int CHAR_W_D    = 5;

  localparam int ALPHABET_SIZE = 26;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_CHAR,
    S_SCAN,
    S_UPDATE,
    S_WIN,
    S_LOSE
  } state_t;

  localparam logic [CHAR_W_D-1:0] LTR_E    = 5'd4;
  localparam logic [CHAR_W_D-1:0] LTR_H    = 5'd7;
  localparam logic [CHAR_W_D-1:0] LTR_L    = 5'd11;
  localparam logic [CHAR_W_D-1:0] LTR_O    = 5'd14;
  localparam logic [CHAR_W_D-1:0] LTR_Z    = 5'd25;
  localparam logic [CHAR_W_D-1:0] CODE_BAD = 5'd26;

endpackage

// File: rtl/hangman_guess_sequencer_if.sv
// Guess-letter valid/ready channel.
// Master offers letters, slave (sequencer) accepts.
interface hangman_guess_sequencer_if
  import hangman_pkg::*;
#(
  parameter int CHAR_W = CHAR_W_D
);
  logic              char_valid;
  logic              char_ready;
  logic [CHAR_W-1:0] char_in;

  modport master (
    output char_valid,
    output char_in,
    input  char_ready
  );

  modport slave (
    input  char_valid,
    input  char_in,
    output char_ready
  );
endinterface

// File: rtl/hangman_guess_sequencer_tries_ctr.sv
// Remaining-tries counter: load full, step down,
// stick at zero.
module hangman_tries_ctr #(
  parameter int MAX = 6,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // load wins over dec; dec at zero holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= W'(MAX);
    end else if (dec && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/hangman_guess_sequencer.sv
// Round FSM for blind hangman: one guess per
// handshake, one word position scanned per cycle.
module hangman_guess_sequencer
  import hangman_pkg::*;
#(
  parameter int WORD_LEN  = WORD_LEN_D,
  parameter int MAX_TRIES = MAX_TRIES_D,
  parameter int CHAR_W    = CHAR_W_D,
  localparam int IW = $clog2(WORD_LEN),
  localparam int TW = $clog2(MAX_TRIES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  hangman_guess_sequencer_if.slave chr,
  output logic [IW-1:0]         word_index,
  input  logic [CHAR_W-1:0]     word_char,
  output logic [WORD_LEN-1:0]   guessed_mask,
  output logic [TW-1:0]         tries_left,
  output logic                  busy,
  output logic                  hit,
  output logic                  miss,
  output logic                  dup,
  output logic                  win,
  output logic                  lose
);

  localparam logic [IW-1:0] LAST = IW'(WORD_LEN - 1);

  state_t state_q, state_d;

  logic [IW-1:0]       idx_q;
  logic [CHAR_W-1:0]   guess_q;
  logic [WORD_LEN-1:0] new_q;
  logic                seen_q;
  logic [WORD_LEN-1:0] mask_q;
  logic                hit_q, miss_q, dup_q;

  logic accept;
  logic has_new;
  logic full;
  logic last_try;
  logic tries_dec;
  logic tries_zero;

  assign accept = chr.char_valid && chr.char_ready
               && (32'(chr.char_in) < ALPHABET_SIZE);
  assign has_new  = (new_q != '0);
  assign full     = &(mask_q | new_q);
  assign last_try = (tries_left == TW'(1)) || tries_zero;

  assign tries_dec = !start && (state_q == S_UPDATE)
                  && !has_new && !seen_q;

  hangman_tries_ctr #(
    .MAX (MAX_TRIES),
    .W   (TW)
  ) u_tries (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start),
    .dec   (tries_dec),
    .count (tries_left),
    .zero  (tries_zero)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next state; start aborts from anywhere
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_WAIT_CHAR;
    end else begin
      unique case (state_q)
        S_WAIT_CHAR: if (accept) state_d = S_SCAN;
        S_SCAN: if (idx_q == LAST) state_d = S_UPDATE;
        S_UPDATE: begin
          if (has_new)
            state_d = full ? S_WIN : S_WAIT_CHAR;
          else if (seen_q)
            state_d = S_WAIT_CHAR;
          else
            state_d = last_try ? S_LOSE : S_WAIT_CHAR;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // state-decoded outputs
  always_comb begin
    chr.char_ready = 1'b0;
    busy           = 1'b0;
    win            = 1'b0;
    lose           = 1'b0;
    unique case (state_q)
      S_WAIT_CHAR: chr.char_ready = 1'b1;
      S_SCAN:      busy = 1'b1;
      S_UPDATE:    busy = 1'b1;
      S_WIN:       win  = 1'b1;
      S_LOSE:      lose = 1'b1;
      default:     ;
    endcase
  end

  // scan index, match accumulators, mask and pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      guess_q <= '0;
      new_q   <= '0;
      seen_q  <= 1'b0;
      mask_q  <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      dup_q   <= 1'b0;
    end else begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      dup_q  <= 1'b0;
      if (start) begin
        idx_q  <= '0;
        new_q  <= '0;
        seen_q <= 1'b0;
        mask_q <= '0;
      end else begin
        unique case (state_q)
          S_WAIT_CHAR: begin
            if (accept) begin
              guess_q <= chr.char_in;
              idx_q   <= '0;
              new_q   <= '0;
              seen_q  <= 1'b0;
            end
          end
          S_SCAN: begin
            if (word_char == guess_q) begin
              if (!mask_q[idx_q]) new_q[idx_q] <= 1'b1;
              else                seen_q <= 1'b1;
            end
            idx_q <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
          end
          S_UPDATE: begin
            mask_q <= mask_q | new_q;
            hit_q  <= has_new;
            dup_q  <= !has_new && seen_q;
            miss_q <= !has_new && !seen_q;
          end
          default: ;
        endcase
      end
    end
  end

  assign word_index   = idx_q;
  assign guessed_mask = mask_q;
  assign hit          = hit_q;
  assign miss         = miss_q;
  assign dup          = dup_q;

endmodule

// File: tb/tb_hangman_guess_sequencer.sv
// Bench for hangman_guess_sequencer: directed
// HELLO rounds plus random rounds vs a set model.
module tb_hangman_guess_sequencer;
  import hangman_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] word_index;
  logic [4:0] word_char;
  logic [4:0] guessed_mask;
  logic [2:0] tries_left;
  logic       busy, hit, miss, dup, win, lose;

  logic [4:0] word [5];

  int ntests = 0;
  int nfail  = 0;

  logic [4:0] m_mask;
  int         m_tries;
  bit         m_win, m_lose;

  hangman_guess_sequencer_if ifc ();

  hangman_guess_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .chr          (ifc),
    .word_index   (word_index),
    .word_char    (word_char),
    .guessed_mask (guessed_mask),
    .tries_left   (tries_left),
    .busy         (busy),
    .hit          (hit),
    .miss         (miss),
    .dup          (dup),
    .win          (win),
    .lose         (lose)
  );

  always #5 clk = ~clk;

  always_comb begin
    word_char = '0;
    if (word_index < 3'd5) word_char = word[word_index];
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input logic [4:0] a,
                          input logic [4:0] b,
                          input logic [4:0] c,
                          input logic [4:0] d,
                          input logic [4:0] e);
    word[0] = a; word[1] = b; word[2] = c;
    word[3] = d; word[4] = e;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mask"}, 32'(guessed_mask), 0);
    chk({tag, "_tries"}, 32'(tries_left), 0);
    chk({tag, "_idx"}, 32'(word_index), 0);
    chk({tag, "_flags"},
        {25'd0, ifc.char_ready, busy, hit, miss,
         dup, win, lose}, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    m_mask = '0; m_tries = 6;
    m_win = 0; m_lose = 0;
    chk("start_tries", 32'(tries_left), 6);
    chk("start_ready", 32'(ifc.char_ready), 1);
    chk("start_mask", 32'(guessed_mask), 0);
    chk("start_wl", {30'd0, win, lose}, 0);
  endtask

  task automatic guess(input logic [4:0] g);
    logic [4:0] mt, nb;
    bit e_hit, e_miss, e_dup, scan_ok;
    chk("ready_pre", 32'(ifc.char_ready), 1);
    ifc.char_in = g;
    ifc.char_valid = 1'b1;
    cyc();
    ifc.char_valid = 1'b0;
    if (g >= 5'd26) begin
      chk("bad_busy", 32'(busy), 0);
      chk("bad_ready", 32'(ifc.char_ready), 1);
      chk("bad_pulse", {29'd0, hit, miss, dup}, 0);
      chk("bad_mask", 32'(guessed_mask), 32'(m_mask));
      return;
    end
    mt = '0;
    for (int i = 0; i < 5; i++)
      if (word[i] == g) mt[i] = 1'b1;
    nb = mt & ~m_mask;
    e_hit = 0; e_miss = 0; e_dup = 0;
    if (nb != 0) begin
      e_hit = 1;
      m_mask = m_mask | nb;
      if (m_mask == 5'b11111) m_win = 1;
    end else if (mt != 0) begin
      e_dup = 1;
    end else begin
      e_miss = 1;
      if (m_tries > 0) m_tries--;
      if (m_tries == 0) m_lose = 1;
    end
    scan_ok = 1;
    for (int k = 0; k < 6; k++) begin
      if (busy !== 1'b1 || ifc.char_ready !== 1'b0
          || {hit, miss, dup} !== 3'b000)
        scan_ok = 0;
      if (k < 5) cyc();
    end
    chk("scan_busy", 32'(scan_ok), 1);
    cyc();
    chk("hit", 32'(hit), 32'(e_hit));
    chk("miss", 32'(miss), 32'(e_miss));
    chk("dup", 32'(dup), 32'(e_dup));
    chk("mask", 32'(guessed_mask), 32'(m_mask));
    chk("tries", 32'(tries_left), 32'(m_tries));
    chk("win", 32'(win), 32'(m_win));
    chk("lose", 32'(lose), 32'(m_lose));
    chk("ready_post", 32'(ifc.char_ready),
        32'(!(m_win || m_lose)));
    chk("busy_post", 32'(busy), 0);
    cyc();
    chk("pulse_clr", {29'd0, hit, miss, dup}, 0);
  endtask

  task automatic poke_ignored(input logic [4:0] g);
    bit quiet;
    quiet = 1;
    ifc.char_in = g;
    ifc.char_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if ({hit, miss, dup, busy, ifc.char_ready} !== 5'b0)
        quiet = 0;
    end
    ifc.char_valid = 1'b0;
    chk("ign_quiet", 32'(quiet), 1);
    chk("ign_mask", 32'(guessed_mask), 32'(m_mask));
    chk("ign_tries", 32'(tries_left), 32'(m_tries));
    chk("ign_wl", {30'd0, win, lose},
        {30'd0, m_win, m_lose});
  endtask

  initial begin
    bit quiet;
    logic [4:0] g;
    ifc.char_valid = 1'b0;
    ifc.char_in = '0;
    set_word(LTR_H, LTR_E, LTR_L, LTR_L, LTR_O);
    m_mask = '0; m_tries = 0; m_win = 0; m_lose = 0;

    repeat (3) cyc();
    check_zero("rst");
    rst_n = 1'b1;
    cyc();
    check_zero("idle");

    do_start();
    guess(LTR_L);
    chk("L_mask", 32'(guessed_mask), 32'h0c);

    do_start();
    guess(LTR_Z);
    guess(LTR_L);
    guess(LTR_L);
    chk("dup_tries", 32'(tries_left), 5);

    do_start();
    for (int i = 0; i < 6; i++) guess(5'(20 + i));
    chk("lose_lvl", 32'(lose), 1);
    poke_ignored(LTR_L);

    do_start();
    guess(LTR_H);
    guess(LTR_E);
    guess(LTR_L);
    guess(LTR_O);
    chk("win_mask", 32'(guessed_mask), 32'h1f);
    poke_ignored(LTR_Z);

    do_start();
    guess(CODE_BAD);
    guess(5'd31);

    ifc.char_in = LTR_Z;
    ifc.char_valid = 1'b1;
    cyc();
    ifc.char_valid = 1'b0;
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("abort_ready", 32'(ifc.char_ready), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_mask", 32'(guessed_mask), 0);
    chk("abort_tries", 32'(tries_left), 6);
    quiet = 1;
    for (int k = 0; k < 8; k++) begin
      if ({hit, miss, dup} !== 3'b0) quiet = 0;
      cyc();
    end
    chk("abort_quiet", 32'(quiet), 1);
    m_mask = '0; m_tries = 6;
    guess(LTR_E);

    ifc.char_in = LTR_L;
    ifc.char_valid = 1'b1;
    cyc();
    ifc.char_valid = 1'b0;
    cyc();
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    cyc();
    rst_n = 1'b1;
    cyc();
    check_zero("post_rst");

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 5; i++)
        word[i] = 5'($urandom_range(0, 7));
      do_start();
      for (int n = 0; n < 30; n++) begin
        if (m_win || m_lose) break;
        if ($urandom_range(0, 9) == 0)
          g = 5'($urandom_range(26, 31));
        else
          g = 5'($urandom_range(0, 10));
        guess(g);
      end
      if (m_win || m_lose) poke_ignored(5'd0);
    end

    $display("[TB] %0d tests run, %0d failed",
             ntests, nfail);
    $finish;
  end

endmodule
